serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
Bit-serial add/subtract sequencer for the 6-bit CPU ALU path. One full_adder cell is time-shared across all operand bits, LSB first, one bit per clock. The sequencer loads the operands, drives the cell and collects sum bits and carry. It returns a WIDTH-bit result plus flags through a start/done handshake.

Parameters:
WIDTH, 6, operand/result width in bits (>=2)
CNT_W, 3, bit-counter width; must satisfy 2**CNT_W >= WIDTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request a new operation; sampled only in IDLE
sub  input  1  0 = a+b, 1 = a-b; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high while bits are being processed (SHIFT state)
done  output  1  one-cycle pulse: result and flags valid
result  output  WIDTH  sum/difference; holds until next accepted start
c_out  output  1  final carry out of MSB (for sub: 1 = no borrow)
overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB
zero  output  1  result == 0

Behaviour:
- Reset (async, any time incl. mid-operation): state=IDLE, busy=0, done=0, result=0, c_out=0, overflow=0, zero=0, count=0, internal shift regs=0, carry=0.
- States: IDLE, SHIFT, DONE (encoding 2 bits).
- IDLE: on a clk edge with start=1: a_sh<=a; b_sh<=sub ? ~b : b; carry<=sub; count<=0; sum_sh<=0; -> SHIFT. Else stay. Outputs result/flags keep their previous values.
- SHIFT: each edge: full_adder inputs (a_sh[0], b_sh[0], carry) produce s and co.
  - sum_sh <= {s, sum_sh[WIDTH-1:1]} (fill from MSB, shift right).
  - a_sh, b_sh shift right by 1 (zero fill); carry <= co.
  - When count==WIDTH-2, capture carry-in of MSB: c_msb_in <= co.
  - When count==WIDTH-1: -> DONE; result <= {s, sum_sh[WIDTH-1:1]}; c_out <= co; overflow <= c_msb_in XOR co; zero <= (that result == 0). Else count<=count+1.
- DONE: done=1 for exactly this one cycle; next edge -> IDLE unconditionally.
- busy = (state==SHIFT); done = (state==DONE); both Moore outputs.
- Latency: start sampled at edge N -> bits processed at edges N+1..N+WIDTH -> done high during cycle after edge N+WIDTH -> IDLE after edge N+WIDTH+1. Back-to-back ops: next start accepted at edge N+WIDTH+2 at earliest (throughput WIDTH+2 cycles/op).
- start while SHIFT or DONE: ignored, no queuing; operands/sub changes during operation have no effect.
- Arithmetic is modulo 2**WIDTH; subtraction is two's complement (a + ~b + 1).
- Unreachable state encoding: -> IDLE on next edge.

Decomposition:
- Shared package/header: state encodings (ST_IDLE, ST_SHIFT, ST_DONE), default WIDTH=6 constant shared with the rest of the 6-bit CPU.
- One sub-module: the existing full_adder (ports a, b, c_in, s, c_out), instantiated once, purely combinational; all sequencing, shifting and flag logic stays in serial_add_ctrl.

Test Plan:
- Add 5+3 (sub=0): done exactly 7 cycles after start edge, result=8, c_out=0, overflow=0, zero=0; busy high for 6 cycles.
- Add 63+1: result=0, c_out=1, zero=1, overflow=0 (-1+1 signed).
- Add 31+1: result=32, c_out=0, overflow=1 (signed +31+1 wraps); then sub 32-1 back-to-back at earliest legal start: result=31, c_out=1, overflow=1.
- Sub 10-3: result=7, c_out=1; sub 3-10: result=57 (6'b111001), c_out=0, overflow=0, zero=0.
- Pulse start with a=1,b=1 during SHIFT of an ongoing 5+3: ignored, first result 8 unaffected, only one done pulse.
- Assert rst mid-SHIFT (after 3 bits) asynchronously, off clock edge: all outputs 0 immediately, state IDLE; next start 2+2 yields result=4 normally.

Source files
------------

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
//   CPU_WIDTH : default datapath width of the 6-bit CPU
//   state_e   : sequencer state encoding (2 bits)
package serial_add_ctrl_pkg;

  localparam int unsigned CPU_WIDTH = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder, purely combinational.
//   a, b, c_in : addend bits and carry in
//   s, c_out   : sum bit and carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer. One full_adder is time-shared over all operand
// bits, LSB first, one bit per clock.
//   clk, rst      : clock, asynchronous active-high reset
//   start, sub    : request an operation (sampled in IDLE); 0 = a+b, 1 = a-b
//   a, b          : operands, sampled with start
//   busy          : high while bits are being processed
//   done          : one-cycle pulse, result and flags valid
//   result        : sum/difference, held until the next accepted start
//   c_out         : carry out of MSB (for subtraction 1 = no borrow)
//   overflow      : signed overflow
//   zero          : result == 0
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = CPU_WIDTH,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
  logic               carry_q, carry_d;
  logic               c_msb_in_q, c_msb_in_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               c_out_q, c_out_d;
  logic               overflow_q, overflow_d;
  logic               zero_q, zero_d;

  logic               fa_s;
  logic               fa_co;
  logic [WIDTH-1:0]   sum_next;

  full_adder u_full_adder (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .c_in  (carry_q),
    .s     (fa_s),
    .c_out (fa_co)
  );

  // Sum bits enter at the MSB, so after WIDTH shifts bit 0 holds the LSB.
  assign sum_next = {fa_s, sum_sh_q[WIDTH-1:1]};

  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    sum_sh_d   = sum_sh_q;
    carry_d    = carry_q;
    c_msb_in_d = c_msb_in_q;
    count_d    = count_q;
    result_d   = result_q;
    c_out_d    = c_out_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Subtraction as a + ~b + 1: the +1 enters as the initial carry.
          a_sh_d   = a;
          b_sh_d   = sub ? ~b : b;
          carry_d  = sub;
          count_d  = '0;
          sum_sh_d = '0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sum_sh_d = sum_next;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = fa_co;
        if (count_q == CNT_W'(WIDTH - 2)) begin
          c_msb_in_d = fa_co;
        end
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d    = ST_DONE;
          result_d   = sum_next;
          c_out_d    = fa_co;
          overflow_d = c_msb_in_q ^ fa_co;
          zero_d     = (sum_next == '0);
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      sum_sh_q   <= '0;
      carry_q    <= 1'b0;
      c_msb_in_q <= 1'b0;
      count_q    <= '0;
      result_q   <= '0;
      c_out_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      sum_sh_q   <= sum_sh_d;
      carry_q    <= carry_d;
      c_msb_in_q <= c_msb_in_d;
      count_q    <= count_d;
      result_q   <= result_d;
      c_out_q    <= c_out_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign busy     = (state_q == ST_SHIFT);
  assign done     = (state_q == ST_DONE);
  assign result   = result_q;
  assign c_out    = c_out_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases with literal expectations plus
// random stimulus, all checked every cycle against a cycle-count/arithmetic model.
module tb_serial_add_ctrl;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         c_out;
  logic         overflow;
  logic         zero;

  int vectors = 0;
  int miscompares = 0;

  serial_add_ctrl #(
    .WIDTH (W),
    .CNT_W (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .c_out    (c_out),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_mode = 0 idle, 1..W = edges since acceptance while busy, W+1 = done cycle.
  int           m_mode = 0;
  logic [W-1:0] m_res = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf = 1'b0;
  logic         m_zero = 1'b0;
  logic [W-1:0] p_res;
  logic         p_cout;
  logic         p_ovf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0;
      m_res  = '0;
      m_cout = 1'b0;
      m_ovf  = 1'b0;
      m_zero = 1'b0;
    end else if (m_mode == 0) begin
      if (start) begin
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic [W-1:0] low;
        bb     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
        low    = {1'b0, a[W-2:0]} + {1'b0, bb[W-2:0]} + {{(W-1){1'b0}}, sub};
        p_res  = full[W-1:0];
        p_cout = full[W];
        p_ovf  = low[W-1] ^ full[W];
        m_mode = 1;
      end
    end else if (m_mode == W) begin
      m_mode = W + 1;
      m_res  = p_res;
      m_cout = p_cout;
      m_ovf  = p_ovf;
      m_zero = (p_res == '0);
    end else if (m_mode == W + 1) begin
      m_mode = 0;
    end else begin
      m_mode++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", int'(busy), int'(m_mode >= 1 && m_mode <= W));
      chk("done", int'(done), int'(m_mode == W + 1));
      chk("result", int'(result), int'(m_res));
      chk("c_out", int'(c_out), int'(m_cout));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("zero", int'(zero), int'(m_zero));
    end
  end

  // Call shortly after a posedge with the DUT idle; returns 1ns after the accepting edge.
  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
    a = ta;
    b = tb;
    sub = ts;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    sub = 1'($urandom);
  endtask

  // Counts falling edges up to and including the done one; leaves DUT idle, 1ns past posedge.
  task automatic wait_done(output int lat, output int nbusy);
    bit ok = 0;
    lat = 0;
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
      if (done) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_res(input string name, input int r, input int c, input int o, input int z);
    chk({name, ".result"}, int'(result), r);
    chk({name, ".c_out"}, int'(c_out), c);
    chk({name, ".overflow"}, int'(overflow), o);
    chk({name, ".zero"}, int'(zero), z);
  endtask

  int lat;
  int nbusy;
  int ndone;

  initial begin
    #12;
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.result", int'(result), 0);
    chk("rst.flags", int'({c_out, overflow, zero}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    op(6'd5, 6'd3, 1'b0);
    wait_done(lat, nbusy);
    chk("add5_3.latency", lat, 7);
    chk("add5_3.busy_cycles", nbusy, 6);
    chk_res("add5_3", 8, 0, 0, 0);

    op(6'd63, 6'd1, 1'b0);
    wait_done(lat, nbusy);
    chk_res("add63_1", 0, 1, 0, 1);

    op(6'd31, 6'd1, 1'b0);
    wait_done(lat, nbusy);
    chk_res("add31_1", 32, 0, 1, 0);
    op(6'd32, 6'd1, 1'b1);
    wait_done(lat, nbusy);
    chk("sub32_1.latency", lat, 7);
    chk_res("sub32_1", 31, 1, 1, 0);

    op(6'd10, 6'd3, 1'b1);
    wait_done(lat, nbusy);
    chk_res("sub10_3", 7, 1, 0, 0);
    op(6'd3, 6'd10, 1'b1);
    wait_done(lat, nbusy);
    chk_res("sub3_10", 57, 0, 0, 0);

    // Start pulse mid-operation must be ignored.
    op(6'd5, 6'd3, 1'b0);
    @(posedge clk);
    #1;
    a = 6'd1;
    b = 6'd1;
    sub = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, nbusy);
    chk_res("ignored_start", 8, 0, 0, 0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("ignored_start.extra_done", ndone, 0);
    @(posedge clk);
    #1;

    // Asynchronous reset after three bits have been processed.
    op(6'd5, 6'd3, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.busy", int'(busy), 0);
    chk("midrst.done", int'(done), 0);
    chk("midrst.result", int'(result), 0);
    chk("midrst.flags", int'({c_out, overflow, zero}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    op(6'd2, 6'd2, 1'b0);
    wait_done(lat, nbusy);
    chk_res("add2_2", 4, 0, 0, 0);

    // Random traffic: start toggles freely, including while busy.
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 2) == 0);
      sub = 1'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    repeat (W + 3) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
